// File: rtl/seq_csa_mult.sv
// Sequential 8x8 unsigned multiplier: one carry-save row reused over 8 cycles, then a final 8-bit add.
// Latency 9 edges from accepting start to done; start is only honoured in IDLE or DONE, never queued.

module carrySave (
   input  logic [7:0] i_a,
   input  logic       i_b,
   input  logic [7:0] i_sum_in,
   input  logic [7:0] i_carry_in,
   output logic [7:0] o_sum_out,
   output logic [7:0] o_carry_out
);
   logic [7:0] w_pp;

   assign w_pp        = i_a & {8{i_b}};
   assign o_sum_out   = w_pp ^ i_sum_in ^ i_carry_in;
   assign o_carry_out = (w_pp & i_sum_in) | (w_pp & i_carry_in) | (i_sum_in & i_carry_in);
endmodule

module seq_csa_mult (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [7:0]  i_a,
   input  logic [7:0]  i_b,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_product
);
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ROW     = 2'd1,
      ST_RESOLVE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_accept;

   logic [7:0]  r_areg;
   logic [7:0]  r_breg;
   logic [7:0]  r_s;
   logic [7:0]  r_c;
   logic [7:0]  r_plo;
   logic [2:0]  r_cnt;
   logic [15:0] r_product;
   logic        r_busy;
   logic        r_done;

   logic        w_b_bit;
   logic [7:0]  w_sum_in;
   logic [7:0]  w_sum_out;
   logic [7:0]  w_carry_out;
   logic [7:0]  w_hi;

   // Saved sum is shifted down one place so each row lines up with the next multiplier bit's weight.
   assign w_b_bit  = r_breg[r_cnt];
   assign w_sum_in = {1'b0, r_s[7:1]};
   assign w_hi     = w_sum_in + r_c;

   carrySave u_row (
      .i_a         (r_areg),
      .i_b         (w_b_bit),
      .i_sum_in    (w_sum_in),
      .i_carry_in  (r_c),
      .o_sum_out   (w_sum_out),
      .o_carry_out (w_carry_out)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_ROW;
            end
         end
         ST_ROW: begin
            if (r_cnt == 3'd7) begin
               w_state_nxt = ST_RESOLVE;
            end
         end
         ST_RESOLVE: begin
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_ROW;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_areg    <= 8'h00;
         r_breg    <= 8'h00;
         r_s       <= 8'h00;
         r_c       <= 8'h00;
         r_plo     <= 8'h00;
         r_cnt     <= 3'd0;
         r_product <= 16'h0000;
      end else if (w_accept) begin
         r_areg <= i_a;
         r_breg <= i_b;
         r_s    <= 8'h00;
         r_c    <= 8'h00;
         r_plo  <= 8'h00;
         r_cnt  <= 3'd0;
      end else if (r_state == ST_ROW) begin
         r_s          <= w_sum_out;
         r_c          <= w_carry_out;
         r_plo[r_cnt] <= w_sum_out[0];
         r_cnt        <= r_cnt + 3'd1;
      end else if (r_state == ST_RESOLVE) begin
         // Cannot overflow: the full product is below 2^16.
         r_product <= {w_hi, r_plo};
      end
   end

   // Status flags are registered from the next state so outputs carry no input-to-output path.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == ST_ROW) || (w_state_nxt == ST_RESOLVE);
         r_done <= (w_state_nxt == ST_DONE);
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_product = r_product;
endmodule

// File: tb/tb_seq_csa_mult.sv
// Bench for seq_csa_mult: cycle-level operation model plus literal checks from worked examples.
module tb_seq_csa_mult;
   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int n_checks = 0;
   int n_errors = 0;

   seq_csa_mult dut (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_start   (start),
      .i_a       (a),
      .i_b       (b),
      .o_busy    (busy),
      .o_done    (done),
      .o_product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: an accepted operation keeps the unit busy for 9 edges, then shows a*b with a done pulse.
   int          m_left  = 0;
   logic        m_done  = 1'b0;
   logic [15:0] m_prod  = 16'h0;
   logic [15:0] m_pend  = 16'h0;
   logic        m_valid = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_prod <= 16'h0;
      end else if (m_left == 0 && start) begin
         m_left <= 9;
         m_pend <= 16'(a) * 16'(b);
         m_done <= 1'b0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_prod <= m_pend;
            m_done <= 1'b1;
         end else begin
            m_done <= 1'b0;
         end
      end else begin
         m_done <= 1'b0;
      end
      if (reset) m_valid <= 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy", {15'b0, busy}, {15'b0, m_left > 0});
         chk("done", {15'b0, done}, {15'b0, m_done});
         chk("product", product, m_prod);
         chk("done_vs_busy", {15'b0, done & busy}, 16'h0);
      end
   end

   task automatic wait_done(input int lim, output int lat, output int nbusy);
      lat   = 0;
      nbusy = 0;
      do begin
         @(negedge clk);
         lat++;
         if (busy) nbusy++;
      end while (!done && lat < lim);
      chk("done_seen", {15'b0, done}, 16'h1);
   endtask

   task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input string nm);
      int lat;
      int nb;
      start = 1'b1; a = x; b = y;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      wait_done(20, lat, nb);
      lat = lat + 1;
      nb  = nb + 1;
      chk({nm, "_product"}, product, exp);
      chk({nm, "_model"}, m_prod, exp);
      chk({nm, "_latency"}, 16'(lat), 16'd10);
      chk({nm, "_busy_cycles"}, 16'(nb), 16'd9);
   endtask

   initial begin
      int lat;
      int nb;
      int ndone;
      reset = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_busy", {15'b0, busy}, 16'h0);
      chk("rst_done", {15'b0, done}, 16'h0);
      chk("rst_product", product, 16'h0000);
      reset = 1'b0;
      @(negedge clk);

      run_op(8'hFF, 8'hFF, 16'hFE01, "ffxff");
      run_op(8'h0D, 8'h0B, 16'h008F, "0dx0b");
      run_op(8'h00, 8'h5A, 16'h0000, "00x5a");
      run_op(8'h01, 8'h80, 16'h0080, "01x80");
      @(negedge clk);

      // Back-to-back with start held high.
      start = 1'b1; a = 8'h12; b = 8'h34;
      wait_done(20, lat, nb);
      chk("b2b_first", product, 16'h03A8);
      a = 8'h02; b = 8'h03;
      @(negedge clk);
      chk("b2b_no_gap", {15'b0, busy}, 16'h1);
      a = 8'h77; b = 8'h99;
      wait_done(20, lat, nb);
      start = 1'b0;
      chk("b2b_spacing", 16'(lat + 1), 16'd10);
      chk("b2b_second", product, 16'h0006);
      repeat (2) @(negedge clk);

      // Starts during a busy op are ignored.
      start = 1'b1; a = 8'h21; b = 8'h43;
      ndone = 0;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         start = (k == 3 || k == 8);
         a = $urandom; b = $urandom;
         if (done) ndone++;
      end
      chk("ignore_one_done", 16'(ndone), 16'd1);
      chk("ignore_product", product, 16'h08A3);

      // Reset mid-row aborts.
      start = 1'b1; a = 8'hAA; b = 8'h55;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {15'b0, busy}, 16'h0);
      chk("abort_done", {15'b0, done}, 16'h0);
      chk("abort_product", product, 16'h0000);
      @(negedge clk);
      run_op(8'hAA, 8'h55, 16'h3872, "aax55");

      // Random sweep: operands churn every cycle, start mostly held, occasional idle gaps.
      for (int n = 0; n < 2000; n++) begin
         start = 1'b1; a = $urandom; b = $urandom;
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
            a = $urandom; b = $urandom;
         end while (!done && lat < 20);
         chk("rand_done_seen", {15'b0, done}, 16'h1);
         if ($urandom_range(0, 7) == 0) begin
            start = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      start = 1'b0;
      repeat (12) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
